// File: rtl/multicycle_control.sv
// Multicycle CPU main control FSM: sequences fetch/decode/execute/memory/writeback.
// Latency: one state per clock; outputs decode the current state combinationally.
// Backpressure: mem_ready low holds FETCH, MEMRD and MEMWR; all other states advance unconditionally.
module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       pcwrite,
    output logic       pcwritecond,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       irwrite,
    output logic       memtoreg,
    output logic       regdst,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ANDIEX  = 4'd9,
        ANDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_e;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_e state_q;
    state_e state_d;

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:   state_d = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYP:      state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ANDI:      state_d = ANDIEX;
                    OP_J:         state_d = JUMP;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR:  state_d = (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   state_d = mem_ready ? MEMWB : MEMRD;
            MEMWB:   state_d = FETCH;
            MEMWR:   state_d = mem_ready ? FETCH : MEMWR;
            EXECUTE: state_d = ALUWB;
            ALUWB:   state_d = FETCH;
            BRANCH:  state_d = FETCH;
            ANDIEX:  state_d = ANDIWB;
            ANDIWB:  state_d = FETCH;
            JUMP:    state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        iord        = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        irwrite     = 1'b0;
        memtoreg    = 1'b0;
        regdst      = 1'b0;
        regwrite    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        pcsrc       = 2'b00;
        aluop       = 2'b00;
        illegal_op  = 1'b0;
        case (state_q)
            FETCH: begin
                memread = 1'b1;
                alusrcb = 2'b01;
                irwrite = mem_ready;
                pcwrite = mem_ready;
            end
            DECODE: begin
                alusrcb = 2'b11;
                // Flag only; the FSM simply refetches on an unknown opcode.
                illegal_op = !(op inside {OP_LW, OP_SW, OP_RTYP, OP_BEQ, OP_ANDI, OP_J});
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            MEMRD: begin
                memread = 1'b1;
                iord    = 1'b1;
            end
            MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            MEMWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
            end
            EXECUTE: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            BRANCH: begin
                alusrca     = 1'b1;
                aluop       = 2'b01;
                pcwritecond = 1'b1;
                pcsrc       = 2'b01;
            end
            ANDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                aluop   = 2'b11;
            end
            ANDIWB: begin
                regwrite = 1'b1;
            end
            JUMP: begin
                pcwrite = 1'b1;
                pcsrc   = 2'b10;
            end
            default: ;
        endcase
    end

    assign state = state_q;

endmodule
